// File: rtl/seg7_pkg.sv
// Shared types and active-low segment patterns for the 4-digit 7-segment scan driver.
// Pattern bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ERR_E = 7'b0000110;

  typedef logic [1:0] digit_idx_t;

  typedef struct packed {
    logic       neg;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } disp_rec_t;

  // What a digit position shows during its slot.
  typedef enum logic [1:0] {
    CELL_BLANK,
    CELL_DIGIT,
    CELL_MINUS
  } cell_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 render as "E".
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] pattern
);

  always_comb begin
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_ERR_E;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode display driver with frame-synchronous updates,
// leading-zero blanking and anti-ghost blanking. Define SEG7_SIGN_FLOAT_EN to float the minus sign.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_DIV   = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd,
  input  logic       neg,
  input  logic [3:0] bcd2,
  input  logic [3:0] bcd1,
  input  logic [3:0] bcd0,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_tick
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] TERM     = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] BLANK_TH = PW'(BLANK_CYC);

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  disp_rec_t     shadow;
  disp_rec_t     disp;
  disp_rec_t     in_rec;
  logic          term;
  logic          frame_end;

  assign in_rec    = '{neg: neg, bcd2: bcd2, bcd1: bcd1, bcd0: bcd0};
  assign term      = (presc == TERM);
  assign frame_end = term && (idx == 2'd3);

  // Content selection for the digit currently being scanned.
  cell_t      cell_sel;
  logic [3:0] sel_bcd;
  logic [6:0] dec_pat;
  logic       nz2, nz1, nz0, show_minus;

  assign nz2        = |disp.bcd2;
  assign nz1        = |disp.bcd1;
  assign nz0        = |disp.bcd0;
  assign show_minus = disp.neg && (nz2 || nz1 || nz0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cell_sel = CELL_BLANK;
    sel_bcd  = disp.bcd0;
    case (idx)
      2'd0: cell_sel = CELL_DIGIT;
      2'd1: begin
        sel_bcd = disp.bcd1;
        if (nz2 || nz1) cell_sel = CELL_DIGIT;
`ifdef SEG7_SIGN_FLOAT_EN
        else if (show_minus) cell_sel = CELL_MINUS;
`endif
      end
      2'd2: begin
        sel_bcd = disp.bcd2;
        if (nz2) cell_sel = CELL_DIGIT;
`ifdef SEG7_SIGN_FLOAT_EN
        else if (nz1 && show_minus) cell_sel = CELL_MINUS;
`endif
      end
      default: begin
`ifdef SEG7_SIGN_FLOAT_EN
        if (nz2 && show_minus) cell_sel = CELL_MINUS;
`else
        if (show_minus) cell_sel = CELL_MINUS;
`endif
      end
    endcase
  end

  seg7_decode u_decode (
    .bcd     (sel_bcd),
    .pattern (dec_pat)
  );

  // Blank digits keep their anode off, as do the leading anti-ghost cycles of every slot.
  logic       lit;
  logic [6:0] seg_next;
  logic [3:0] an_next;

  assign lit      = (presc >= BLANK_TH) && (cell_sel != CELL_BLANK);
  assign seg_next = !lit                    ? SEG_BLANK :
                    (cell_sel == CELL_MINUS) ? SEG_MINUS : dec_pat;
  assign an_next  = lit ? ~(4'b0001 << idx) : 4'hF;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc      <= '0;
      idx        <= '0;
      shadow     <= '0;
      disp       <= '0;
      seg        <= SEG_BLANK;
      an         <= 4'hF;
      frame_tick <= 1'b0;
    end else begin
      if (term) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end

      if (upd) shadow <= in_rec;
      // A strobe landing on the frame-end cycle bypasses the shadow to avoid a one-frame lag.
      if (frame_end) disp <= upd ? in_rec : shadow;

      seg        <= seg_next;
      an         <= an_next;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus queues the expected contents of each frame,
// a monitor accumulates what is lit during the frame and compares at every frame_tick.
module tb_seg7_scan_driver;

  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010;
  localparam logic [6:0] P6 = 7'b0000010;
  localparam logic [6:0] P7 = 7'b1111000;
  localparam logic [6:0] P8 = 7'b0000000;
  localparam logic [6:0] PE = 7'b0000110;
  localparam logic [6:0] PM = 7'b0111111;
  localparam logic [6:0] PB = 7'b1111111;

  localparam int FRAME_LEN = 32;
  localparam int LIT_CYC   = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd;
  logic       neg;
  logic [3:0] bcd2, bcd1, bcd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_tick;

  seg7_scan_driver #(.CLK_DIV(8), .BLANK_CYC(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd        (upd),
    .neg        (neg),
    .bcd2       (bcd2),
    .bcd1       (bcd1),
    .bcd0       (bcd0),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] d3;
    logic [6:0] d2;
    logic [6:0] d1;
    logic [6:0] d0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] d3, d2, d1, d0);
    exp_q.push_back('{d3: d3, d2: d2, d1: d1, d0: d0});
  endtask

  task automatic pulse_upd(input logic n, input logic [3:0] b2, b1, b0);
    neg = n; bcd2 = b2; bcd1 = b1; bcd0 = b0;
    upd = 1'b1;
    @(posedge clk);
    #1 upd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns one time unit after the edge that raised frame_tick.
  task automatic next_frame();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_tick && n < 2 * FRAME_LEN);
    check("frame_tick_seen", 32'(frame_tick), 32'd1);
  endtask

  // Monitor: accumulate lit digits per frame, compare against the queue head at frame_tick.
  logic [6:0] pat[4];
  int         cnt[4];
  int         nsamp;
  logic       glitch;

  task automatic clear_acc();
    for (int i = 0; i < 4; i++) begin
      pat[i] = PB;
      cnt[i] = 0;
    end
    nsamp  = 0;
    glitch = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      clear_acc();
    end else begin
      int d;
      nsamp++;
      d = -1;
      case (an)
        4'b1111: if (seg !== PB) glitch = 1'b1;
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: glitch = 1'b1;
      endcase
      if (d >= 0) begin
        if (cnt[d] != 0 && pat[d] !== seg) glitch = 1'b1;
        pat[d] = seg;
        cnt[d]++;
      end
      if (frame_tick) begin
        check("scoreboard_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t       e;
          logic [6:0] ep[4];
          e = exp_q.pop_front();
          ep[0] = e.d0; ep[1] = e.d1; ep[2] = e.d2; ep[3] = e.d3;
          check("frame_length", 32'(nsamp), 32'(FRAME_LEN));
          check("frame_clean", 32'(glitch), 32'd0);
          for (int i = 0; i < 4; i++)
            check($sformatf("digit%0d_{count,seg}", i), {16'(cnt[i]), 9'd0, pat[i]},
                  {16'((ep[i] == PB) ? 0 : LIT_CYC), 9'd0, ep[i]});
        end
        clear_acc();
      end
    end
  end

  initial begin
    rst_n = 1'b0; upd = 1'b0; neg = 1'b0; bcd2 = '0; bcd1 = '0; bcd0 = '0;
    idle(3);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_an", 32'(an), 32'hF);
    check("reset_frame_tick", 32'(frame_tick), 32'd0);

    // Frame 1: cleared display shows just "0".
    push_exp(PB, PB, PB, P0);
    @(negedge clk); #1 rst_n = 1'b1;
    next_frame();

    // Frame 2: mid-frame update of 500 must not show yet.
    push_exp(PB, PB, PB, P0);
    idle(5); pulse_upd(1'b0, 4'd5, 4'd0, 4'd0);
    next_frame();

    // Frame 3: 500 visible; queue -42.
    push_exp(PB, P5, P0, P0);
    idle(5); pulse_upd(1'b1, 4'd0, 4'd4, 4'd2);
    next_frame();

    // Frame 4: -42; queue negative zero.
`ifdef SEG7_SIGN_FLOAT_EN
    push_exp(PB, PM, P4, P2);
`else
    push_exp(PM, PB, P4, P2);
`endif
    idle(5); pulse_upd(1'b1, 4'd0, 4'd0, 4'd0);
    next_frame();

    // Frame 5: "0" with no sign; strobe 123 exactly on the frame-end cycle.
    push_exp(PB, PB, PB, P0);
    idle(31); pulse_upd(1'b0, 4'd1, 4'd2, 4'd3);

    // Frame 6: bypassed 123 visible at once; 777 arrives 3 cycles into the frame.
    push_exp(PB, P1, P2, P3);
    idle(2); pulse_upd(1'b0, 4'd7, 4'd7, 4'd7);
    next_frame();

    // Frame 7: 777; queue invalid units digit.
    push_exp(PB, P7, P7, P7);
    idle(5); pulse_upd(1'b0, 4'd0, 4'd0, 4'hC);
    next_frame();

    // Frame 8: "E"; queue -5.
    push_exp(PB, PB, PB, PE);
    idle(5); pulse_upd(1'b1, 4'd0, 4'd0, 4'd5);
    next_frame();

    // Frame 9: -5; queue -500.
`ifdef SEG7_SIGN_FLOAT_EN
    push_exp(PB, PB, PM, P5);
`else
    push_exp(PM, PB, PB, P5);
`endif
    idle(5); pulse_upd(1'b1, 4'd5, 4'd0, 4'd0);
    next_frame();

    // Frame 10: -500; two strobes, the last (68) wins.
    push_exp(PM, P5, P0, P0);
    idle(5); pulse_upd(1'b0, 4'd9, 4'd9, 4'd9);
    idle(8); pulse_upd(1'b0, 4'd0, 4'd6, 4'd8);
    next_frame();

    // Frame 11 is aborted by an asynchronous reset while a digit is lit.
    push_exp(PB, PB, P6, P8);
    for (int i = 0; i < 40 && an == 4'hF; i++) idle(1);
    check("lit_before_reset", 32'(an != 4'hF), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_seg", 32'(seg), 32'h7F);
    check("async_reset_an", 32'(an), 32'hF);
    check("async_reset_frame_tick", 32'(frame_tick), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);

    // Frame 12: display cleared, scan restarts at index 0 with a full-length frame.
    push_exp(PB, PB, PB, P0);
    #1 rst_n = 1'b1;
    next_frame();
    @(negedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the binary-to-BCD stage.
- Takes a sign flag and three BCD digits (hundreds/tens/units), latches them, and time-multiplexes them onto a 4-digit common-anode 7-segment display.
- Digit 3 (leftmost) carries the minus sign.
- Provides leading-zero blanking, tear-free frame-synchronous updates and inter-digit anti-ghosting blanking.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYC, 500, cycles at the start of each slot with all anodes off; must be < CLK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- upd  input  1  one-cycle strobe; capture bcd2/bcd1/bcd0/neg
- neg  input  1  value is negative
- bcd2  input  4  hundreds digit
- bcd1  input  4  tens digit
- bcd0  input  4  units digit
- seg  output  7  {g,f,e,d,c,b,a}, active-low
- an  output  4  digit enables, active-low; an[0] = rightmost
- frame_tick  output  1  one-cycle pulse at each frame end (new values become visible)

Behaviour:
- Reset, asynchronous on rst_n low:
  - seg=7'h7F, an=4'hF, frame_tick=0.
  - Prescaler=0, digit index=0.
  - Shadow and display registers cleared (neg=0, digits=0).
  - Reset mid-frame aborts the scan immediately; the display is dark until reset is released.
- Prescaler: counts 0..CLK_DIV-1.
  - At terminal count it wraps to 0 and digit index advances 0→1→2→3→0.
  - Slot = CLK_DIV cycles; frame = 4*CLK_DIV cycles.
- Registers:
  - upd loads the shadow register.
  - Display register loads from shadow at frame end (index 3 AND prescaler terminal); frame_tick pulses that same cycle.
  - upd coincident with frame end: the new input goes to both shadow and display (bypass).
  - Multiple upd within one frame: last one wins.
- Outputs are registered and lag internal state by one cycle.
  - Anodes: an[idx]=0 only when prescaler ≥ BLANK_CYC; all other an bits 1.
  - During blanking cycles: an=4'hF and seg=7'h7F.
- Decode (active-low patterns):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Minus=0111111, blank=1111111.
  - Invalid BCD (10..15)=0000110 ("E"); an invalid digit counts as nonzero for blanking.
- Leading-zero blanking:
  - Digit 0 (bcd0) is always shown.
  - Digit 1 is blank iff bcd2==0 and bcd1==0.
  - Digit 2 is blank iff bcd2==0.
- Sign:
  - Digit 3 shows minus if neg and any digit is nonzero; otherwise digit 3 is blank.
  - Negative zero displays as "0".

Optional Feature:
- Macro: SEG7_SIGN_FLOAT_EN.
- Defined: the minus sign floats into the digit immediately left of the most significant displayed digit. Positions to its left are blank.
  - -5 → digit1='-'
  - -42 → digit2='-'
  - -500 → digit3='-'
- Undefined: the minus sign is fixed in digit 3.
- Zero suppression of the sign applies in both builds.

Decomposition:
- Package seg7_pkg:
  - 7-bit segment pattern constants (digits 0-9, MINUS, BLANK, ERR_E).
  - 2-bit digit-index typedef.
  - Display-record struct {neg, bcd2, bcd1, bcd0}.
- Sub-module seg7_decode: combinational 4-bit BCD → 7-bit active-low pattern, with the invalid-to-E rule.
- Top-level scan driver holds the prescaler, index, shadow/display registers, blanking/sign muxing and output registers.

Test Plan (CLK_DIV=8, BLANK_CYC=2):
- Reset released, no upd → per slot: an low for 6 cycles per slot on an[0] with seg=1000000; an[1..3] slots keep an=4'hF throughout (blanked digits); frame_tick every 32 cycles.
- upd with neg=0, bcd=5,0,0 mid-frame → display unchanged until frame_tick; next frame shows digit2='5', digit1='0', digit0='0', digit3 blank.
- upd with neg=1, bcd=0,4,2 → digit3='-' (SEG7_SIGN_FLOAT_EN: digit2='-', digit3 blank), digit2 blank, digit1='4', digit0='2'.
- upd with neg=1, bcd=0,0,0 → only digit0='0'; no minus anywhere.
- upd pulsed exactly at the frame-end cycle with bcd=1,2,3 → those values are shown in the very next frame; a second upd with 7,7,7 issued 3 cycles later → 7,7,7 appears one frame after that.
- bcd0=4'hC → digit0=0000110; rst_n dropped mid-slot → seg=7'h7F and an=4'hF asynchronously; after release the first slot starts at index 0.
